// File: rtl/uart_packet_decoder_if.sv
// rtl/uart_packet_decoder_if.sv - byte-stream input and write-word handshake bundle for uart_packet_decoder
interface uart_packet_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [11:0] wr_data;

    modport master (
        output rx_data, rx_valid, wr_ready,
        input  wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  rx_data, rx_valid, wr_ready,
        output wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/uart_packet_decoder.sv
// rtl/uart_packet_decoder.sv - frames uart_rx bytes into {addr,data} write words, dump requests and error reports
// Optional checksum byte after the payload is enabled by defining PKT_CHECKSUM_EN.
module uart_packet_decoder #(
    parameter logic [7:0] START_BYTE     = 8'hF5,
    parameter logic [7:0] STOP_BYTE      = 8'hFA,
    parameter logic [7:0] DUMP_BYTE      = 8'hF6,
    parameter int         TIMEOUT_CYCLES = 21700
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_packet_decoder_if.slave   bus,
    output logic                   dump_req,
    output logic                   err_pulse,
    output logic [7:0]             err_count,
    output logic                   busy
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PAYLOAD   = 2'd1;
    localparam logic [1:0] S_WAIT_STOP = 2'd2;
`ifdef PKT_CHECKSUM_EN
    localparam logic [1:0] S_CKSUM     = 2'd3;
`endif

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [9:0]       addr_q, addr_d;
    logic [11:0]      data_q, data_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wr_valid_q, wr_valid_d;
    logic [9:0]       wr_addr_q, wr_addr_d;
    logic [11:0]      wr_data_q, wr_data_d;
    logic             dump_q, dump_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
`ifdef PKT_CHECKSUM_EN
    logic [5:0]       csum_q, csum_d;
`endif

    logic       commit;
    logic       perr;
    logic       ovr;
    logic       hs;
    logic [7:0] rx;

    assign rx = bus.rx_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        dump_d  = 1'b0;
        commit  = 1'b0;
        perr    = 1'b0;
`ifdef PKT_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (bus.rx_valid) begin
            tmo_d = '0;
            if (rx == START_BYTE) begin
                perr    = (state_q != S_IDLE);
                state_d = S_PAYLOAD;
                cnt_d   = 2'd0;
`ifdef PKT_CHECKSUM_EN
                csum_d  = 6'd0;
`endif
            end else if (rx == DUMP_BYTE) begin
                dump_d  = (state_q == S_IDLE);
                perr    = (state_q != S_IDLE);
                state_d = S_IDLE;
            end else if (rx[7:4] == 4'hF) begin
                // Every control-range byte ends the packet; only STOP after a full payload commits.
                if (rx == STOP_BYTE && state_q == S_WAIT_STOP) commit = 1'b1;
                else                                            perr   = 1'b1;
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_PAYLOAD: begin
                        if (cnt_q[1] ? (rx[7:6] != 2'b00) : (rx[7:5] != 3'b000)) begin
                            perr    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            case (cnt_q)
                                2'd0:    addr_d[9:5]  = rx[4:0];
                                2'd1:    addr_d[4:0]  = rx[4:0];
                                2'd2:    data_d[11:6] = rx[5:0];
                                default: data_d[5:0]  = rx[5:0];
                            endcase
                            cnt_d = cnt_q + 2'd1;
`ifdef PKT_CHECKSUM_EN
                            csum_d = csum_q ^ rx[5:0];
                            if (cnt_q == 2'd3) state_d = S_CKSUM;
`else
                            if (cnt_q == 2'd3) state_d = S_WAIT_STOP;
`endif
                        end
                    end
`ifdef PKT_CHECKSUM_EN
                    S_CKSUM: begin
                        if (rx[7:6] != 2'b00 || rx[5:0] != csum_q) begin
                            perr    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
`endif
                    S_WAIT_STOP: begin
                        perr    = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                perr    = 1'b1;
                state_d = S_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
    end

    // Output word register runs independently so the parser can accept the next packet meanwhile.
    always_comb begin
        hs         = wr_valid_q & bus.wr_ready;
        ovr        = commit & wr_valid_q & ~bus.wr_ready;
        wr_valid_d = wr_valid_q & ~hs;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (commit && !ovr) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = data_q;
        end
        err_d     = perr | ovr;
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= 10'd0;
            data_q     <= 12'd0;
            tmo_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 10'd0;
            wr_data_q  <= 12'd0;
            dump_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= 6'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            dump_q     <= dump_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign dump_req     = dump_q;
    assign err_pulse    = err_q;
    assign err_count    = err_cnt_q;
    assign busy         = (state_q != S_IDLE);
endmodule
